// File: rtl/slice_sched_pkg.sv
// Shared types and sizing helpers for the time-slice scheduler.
// Imported by the top level and by the round-robin picker.
package slice_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    GAP
  } state_e;

  localparam int DEF_N_REQ = 4;
  localparam int DEF_WIDTH = 8;

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/slice_scheduler_rr_pick.sv
// Combinational round-robin selector.
// Scans upward from ptr_i+1, wrapping modulo N_REQ.
module rr_pick
  import slice_sched_pkg::*;
#(
  parameter  int N_REQ = DEF_N_REQ,
  localparam int PW    = ptr_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [PW-1:0]    ptr_i,
  output logic [N_REQ-1:0] pick_o,
  output logic [PW-1:0]    idx_o,
  output logic             any_o
);

  always_comb begin
    int j;
    logic [PW-1:0] k;
    j      = 0;
    k      = '0;
    pick_o = '0;
    idx_o  = '0;
    any_o  = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      j = (int'(ptr_i) + i) % N_REQ;
      k = PW'(j);
      if (!any_o && req_i[k]) begin
        any_o     = 1'b1;
        idx_o     = k;
        pick_o[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/slice_scheduler.sv
// Round-robin time-slice scheduler for a shared cycle counter.
// Grants last a quantum of enabled cycles or until the holder drops req.
module slice_scheduler
  import slice_sched_pkg::*;
#(
  parameter  int N_REQ = DEF_N_REQ,
  parameter  int WIDTH = DEF_WIDTH,
  localparam int PW    = ptr_w(N_REQ)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic [N_REQ-1:0] req,
  input  logic [WIDTH-1:0] quantum,
  output logic [N_REQ-1:0] grant,
  output logic [PW-1:0]    grant_id,
  output logic             busy,
  output logic [WIDTH-1:0] slice_count,
  output logic             expire
);

  state_e state_q, state_d;

  logic [N_REQ-1:0] grant_q, grant_d;
  logic [PW-1:0]    id_q, id_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic             busy_q, busy_d;
  logic             exp_q, exp_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] qnt_q, qnt_d;

  logic [N_REQ-1:0] pick;
  logic [PW-1:0]    pick_idx;
  logic             pick_any;
  logic             rel;
  logic             hit;
  logic [WIDTH-1:0] last;

  rr_pick #(
    .N_REQ(N_REQ)
  ) u_pick (
    .req_i (req),
    .ptr_i (ptr_q),
    .pick_o(pick),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  // quantum 0 wraps to 2^WIDTH-1, giving a full 2^WIDTH slice
  assign last = qnt_q - WIDTH'(1);
  assign rel  = !req[id_q];
  assign hit  = enable && (cnt_q == last);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (enable && pick_any) state_d = GRANT;
      GRANT:   if (rel || hit)         state_d = GAP;
      GAP:                             state_d = IDLE;
      default:                         state_d = IDLE;
    endcase
  end

  always_comb begin
    grant_d = grant_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    busy_d  = busy_q;
    exp_d   = 1'b0;
    cnt_d   = cnt_q;
    qnt_d   = qnt_q;
    unique case (state_q)
      IDLE: begin
        if (enable && pick_any) begin
          grant_d = pick;
          id_d    = pick_idx;
          busy_d  = 1'b1;
          cnt_d   = '0;
          qnt_d   = quantum;
        end
      end
      GRANT: begin
        if (enable) cnt_d = cnt_q + WIDTH'(1);
        if (rel || hit) begin
          grant_d = '0;
          busy_d  = 1'b0;
          exp_d   = !rel;
        end
      end
      GAP:     ptr_d = id_q;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant_q <= '0;
      id_q    <= '0;
      ptr_q   <= PW'(N_REQ - 1);
      busy_q  <= 1'b0;
      exp_q   <= 1'b0;
      cnt_q   <= '0;
      qnt_q   <= '0;
    end else begin
      grant_q <= grant_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
      exp_q   <= exp_d;
      cnt_q   <= cnt_d;
      qnt_q   <= qnt_d;
    end
  end

  assign grant       = grant_q;
  assign grant_id    = id_q;
  assign busy        = busy_q;
  assign slice_count = cnt_q;
  assign expire      = exp_q;

endmodule

// File: tb/tb_slice_scheduler.sv
// Directed scoreboard bench for slice_scheduler.
// Expected grants are queued as stimulus is applied.
module tb_slice_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [3:0] req;
  logic [7:0] quantum;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       busy;
  logic [7:0] slice_count;
  logic       expire;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] g;
    int         len;
    int         lat;
    int         cnt;
    int         pulses;
    int         mx;
  } exp_t;

  exp_t sbq[$];

  slice_scheduler dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .req        (req),
    .quantum    (quantum),
    .grant      (grant),
    .grant_id   (grant_id),
    .busy       (busy),
    .slice_count(slice_count),
    .expire     (expire)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [3:0] g, input int len, input int lat,
                      input int cnt, input int pulses, input int mx);
    exp_t e;
    e.g = g; e.len = len; e.lat = lat;
    e.cnt = cnt; e.pulses = pulses; e.mx = mx;
    sbq.push_back(e);
  endtask

  task automatic run_grant(input string tag, input int drop_at,
                           input int gate_at, input int abort_at);
    exp_t e;
    int lat, len, pulses, mx, eid, ca;
    e = sbq.pop_front();
    eid = 0;
    for (int i = 0; i < 4; i++) if (e.g[i]) eid = i;
    lat = 0; len = 0; pulses = 0; mx = 0; ca = 0;
    do begin
      tick();
      lat++;
      if (expire) pulses++;
    end while (grant == 4'b0 && lat < 300);
    chk({tag, "_lat"}, lat, e.lat);
    chk({tag, "_grant"}, int'(grant), int'(e.g));
    chk({tag, "_id"}, int'(grant_id), eid);
    chk({tag, "_busy"}, int'(busy), 1);
    while (grant === e.g && len < 400) begin
      if (int'(slice_count) > mx) mx = int'(slice_count);
      len++;
      if (len == drop_at) req = 4'b0;
      if (gate_at > 0 && len == gate_at + 1) ca = int'(slice_count);
      if (gate_at > 0 && len == gate_at + 4) begin
        chk({tag, "_frozen"}, int'(slice_count), ca);
        enable = 1'b1;
      end
      if (gate_at > 0 && len == gate_at) enable = 1'b0;
      if (len == abort_at) return;
      tick();
      if (expire) pulses++;
    end
    chk({tag, "_len"}, len, e.len);
    chk({tag, "_cnt"}, int'(slice_count), e.cnt);
    chk({tag, "_max"}, mx, e.mx);
    chk({tag, "_expire"}, pulses, e.pulses);
    chk({tag, "_idle_busy"}, int'(busy), 0);
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; req = 4'b0; quantum = 8'd0;
    tick(2);
    chk("rst_grant", int'(grant), 0);
    chk("rst_id", int'(grant_id), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_cnt", int'(slice_count), 0);
    chk("rst_expire", int'(expire), 0);
    reset = 1'b1;
    tick();

    enable = 1'b1; quantum = 8'd5; req = 4'b0001;
    push(4'b0001, 5, 1, 5, 1, 4);
    run_grant("q5", 0, 0, 0);
    req = 4'b0;
    tick();
    chk("q5_gap_grant", int'(grant), 0);
    chk("q5_gap_expire", int'(expire), 0);
    tick(2);

    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    quantum = 8'd3; req = 4'b1111;
    push(4'b0001, 3, 1, 3, 1, 2);
    push(4'b0010, 3, 2, 3, 1, 2);
    push(4'b0100, 3, 2, 3, 1, 2);
    push(4'b1000, 3, 2, 3, 1, 2);
    push(4'b0001, 3, 2, 3, 1, 2);
    for (int i = 0; i < 5; i++) begin
      run_grant($sformatf("rr%0d", i), 0, 0, 0);
      quantum = 8'd9;
      if (i < 4) quantum = 8'd3;
    end
    req = 4'b0;
    tick(3);

    quantum = 8'd10; req = 4'b0100;
    push(4'b0100, 2, 1, 2, 0, 1);
    run_grant("rel", 2, 0, 0);
    tick(3);
    chk("rel_hold_cnt", int'(slice_count), 2);
    chk("rel_hold_id", int'(grant_id), 2);

    quantum = 8'd6; req = 4'b0001;
    push(4'b0001, 10, 1, 6, 1, 5);
    run_grant("gate", 0, 2, 0);
    req = 4'b0;
    tick(3);

    quantum = 8'd0; req = 4'b0001;
    push(4'b0001, 256, 1, 0, 1, 255);
    run_grant("q0", 0, 0, 0);
    req = 4'b0;
    tick(3);

    quantum = 8'd20; req = 4'b1000;
    push(4'b1000, 0, 1, 0, 0, 0);
    run_grant("pre", 0, 0, 3);
    #3 reset = 1'b0;
    #1;
    chk("arst_grant", int'(grant), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_cnt", int'(slice_count), 0);
    chk("arst_id", int'(grant_id), 0);
    chk("arst_expire", int'(expire), 0);
    @(negedge clk);
    reset = 1'b1; req = 4'b1010;
    push(4'b0010, 20, 1, 20, 1, 19);
    run_grant("post", 0, 0, 0);
    req = 4'b0;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
